// File: rtl/cpu_sequencer_if.sv
// Memory-side bus of the CPU sequencer: program-memory fetch port and data-memory port.
// master = sequencer side, slave = memory side.
interface cpu_sequencer_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 16
);
    logic               pm_rd;
    logic [PC_W-1:0]    pm_addr;
    logic [INSTR_W-1:0] pm_rdata;
    logic               pm_valid;
    logic               dm_req;
    logic               dm_we;
    logic [PC_W-1:0]    dm_addr;
    logic               dm_ready;

    modport master (
        output pm_rd, pm_addr, dm_req, dm_we, dm_addr,
        input  pm_rdata, pm_valid, dm_ready
    );

    modport slave (
        input  pm_rd, pm_addr, dm_req, dm_we, dm_addr,
        output pm_rdata, pm_valid, dm_ready
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer for the 16-bit accumulator CPU: fetches into IR,
// strobes ALU ops, and turns LD/ST into handshaked data-memory transfers.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | stopped at an instruction boundary, halted=1, waits for run
// S_FETCH | pm_rd held until pm_valid; IR loaded, pc advanced
// S_EXEC  | decoder sampled; ALU op retires here, memory ops go to S_MEM
// S_MEM   | dm_req held until dm_ready; stores retire here
// S_WB    | load data captured (load_en), load retires
module cpu_sequencer #(
    parameter int              PC_W     = 10,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    cpu_sequencer_if.master    bus,
    output logic [INSTR_W-1:0] ir,
    input  logic               dec_mem_rd,
    input  logic               dec_mem_wr,
    output logic               exec_en,
    output logic               load_en,
    output logic               instr_done,
    output logic               halted,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic            we_q;
    logic            pm_rd;
    logic            dm_req;
    logic            is_mem;

    assign is_mem = dec_mem_rd | dec_mem_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
            we_q  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && bus.pm_valid) begin
                ir <= bus.pm_rdata;
                pc <= pc + PC_W'(1);
            end
            // Direction is frozen here so a decoder glitch during MEM cannot flip it.
            if (state == S_EXEC) begin
                we_q <= dec_mem_wr;
                if (dec_mem_rd && dec_mem_wr) begin
                    err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        pm_rd      = 1'b0;
        dm_req     = 1'b0;
        exec_en    = 1'b0;
        load_en    = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (state)
            S_IDLE: begin
                halted = 1'b1;
                if (run) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                pm_rd = 1'b1;
                if (bus.pm_valid) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem) begin
                    state_nxt = S_MEM;
                end else begin
                    exec_en    = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = run ? S_FETCH : S_IDLE;
                end
            end
            S_MEM: begin
                dm_req = 1'b1;
                if (bus.dm_ready) begin
                    if (we_q) begin
                        instr_done = 1'b1;
                        state_nxt  = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                load_en    = 1'b1;
                instr_done = 1'b1;
                state_nxt  = run ? S_FETCH : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.pm_rd   = pm_rd;
    assign bus.pm_addr = pc;
    assign bus.dm_req  = dm_req;
    assign bus.dm_we   = dm_req & we_q;
    assign bus.dm_addr = ir[PC_W-1:0];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues expected fetches, memory
// transfers and retirements; a monitor pops and compares them as the DUT presents them.
module tb_cpu_sequencer;

    localparam int K_F  = 0;
    localparam int K_M  = 1;
    localparam int K_EX = 2;
    localparam int K_LD = 3;
    localparam int K_ST = 4;

    typedef struct {
        int         kind;
        logic [9:0] addr;
        logic       we;
        int         n;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] ir;
    logic        dec_mem_rd;
    logic        dec_mem_wr;
    logic        exec_en;
    logic        load_en;
    logic        instr_done;
    logic        halted;
    logic        err;

    cpu_sequencer_if #(.PC_W(10), .INSTR_W(16)) bus ();

    cpu_sequencer #(.PC_W(10), .INSTR_W(16), .RESET_PC(10'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .bus        (bus),
        .ir         (ir),
        .dec_mem_rd (dec_mem_rd),
        .dec_mem_wr (dec_mem_wr),
        .exec_en    (exec_en),
        .load_en    (load_en),
        .instr_done (instr_done),
        .halted     (halted),
        .err        (err)
    );

    logic [15:0] pm_mem [0:1023];
    int          dm_lat [0:1023];
    int          pm_wait;
    int          pm_cnt;
    int          dm_cnt;
    int          cyc;
    int          fetch_cyc;
    int          req_cnt;
    int          done_cnt;
    int          checks;
    int          errors;
    exp_t        sb [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Decoder model: opcode 4 = LD, 6 = ST, 7 = illegal LD+ST.
    assign dec_mem_rd = (ir[15:12] == 4'h4) || (ir[15:12] == 4'h7);
    assign dec_mem_wr = (ir[15:12] == 4'h6) || (ir[15:12] == 4'h7);

    assign bus.pm_rdata = pm_mem[bus.pm_addr];
    assign bus.pm_valid = bus.pm_rd && (pm_cnt == pm_wait);
    assign bus.dm_ready = bus.dm_req && (dm_cnt == dm_lat[bus.dm_addr]);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_cnt <= 0;
            dm_cnt <= 0;
        end else begin
            pm_cnt <= (bus.pm_rd && !bus.pm_valid) ? pm_cnt + 1 : 0;
            dm_cnt <= (bus.dm_req && !bus.dm_ready) ? dm_cnt + 1 : 0;
        end
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic push_f(input int a);
        exp_t e;
        e.kind = K_F; e.addr = 10'(a); e.we = 1'b0; e.n = 0;
        sb.push_back(e);
    endtask

    task automatic push_m(input int a, input logic we, input int n);
        exp_t e;
        e.kind = K_M; e.addr = 10'(a); e.we = we; e.n = n;
        sb.push_back(e);
    endtask

    task automatic push_d(input int kind, input int lat);
        exp_t e;
        e.kind = kind; e.addr = '0; e.we = 1'b0; e.n = lat;
        sb.push_back(e);
    endtask

    task automatic pop_exp(input string who, output exp_t e, output bit ok);
        e.kind = -1; e.addr = '0; e.we = 1'b0; e.n = 0;
        if (sb.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: unexpected event, scoreboard empty", who);
            ok = 1'b0;
        end else begin
            e  = sb.pop_front();
            ok = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        int   kind;
        if (!rst_n) begin
            req_cnt = 0;
        end else begin
            if (bus.dm_req) req_cnt = req_cnt + 1;
            chk("strobe_exclusive", 32'((exec_en && load_en) || (bus.pm_rd && bus.dm_req)), 32'd0);
            if (bus.pm_rd && bus.pm_valid) begin
                pop_exp("fetch", e, ok);
                if (ok) begin
                    chk("fetch_kind", 32'(K_F), 32'(e.kind));
                    chk("fetch_addr", 32'(bus.pm_addr), 32'(e.addr));
                end
                fetch_cyc = cyc;
            end
            if (bus.dm_req && bus.dm_ready) begin
                pop_exp("dm_xfer", e, ok);
                if (ok) begin
                    chk("dm_kind", 32'(K_M), 32'(e.kind));
                    chk("dm_addr", 32'(bus.dm_addr), 32'(e.addr));
                    chk("dm_we", 32'(bus.dm_we), 32'(e.we));
                    chk("dm_req_cycles", 32'(req_cnt), 32'(e.n));
                end
                req_cnt = 0;
            end
            if (instr_done) begin
                done_cnt = done_cnt + 1;
                kind = exec_en ? K_EX : (load_en ? K_LD : K_ST);
                pop_exp("retire", e, ok);
                if (ok) begin
                    chk("retire_kind", 32'(kind), 32'(e.kind));
                    chk("retire_latency", 32'(cyc - fetch_cyc), 32'(e.n));
                end
            end
        end
    end

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("retire_count", 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_dm_req(input int budget);
        int k;
        k = 0;
        while (!bus.dm_req && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("dm_req_seen", 32'(bus.dm_req), 32'd1);
    endtask

    task automatic check_idle(input string tag, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk); #1;
            chk({tag, "_halted"}, 32'(halted), 32'd1);
            chk({tag, "_pm_rd"}, 32'(bus.pm_rd), 32'd0);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; fetch_cyc = 0; req_cnt = 0; done_cnt = 0;
        pm_wait = 0;
        for (int i = 0; i < 1024; i++) begin
            pm_mem[i] = 16'h0000;
            dm_lat[i] = 0;
        end
        pm_mem[0] = 16'h0123;
        pm_mem[1] = 16'h4155;
        pm_mem[2] = 16'h63FF;
        pm_mem[4] = 16'h4155;
        dm_lat[10'h155] = 2;
        run   = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_pm_rd", 32'(bus.pm_rd), 32'd0);
        chk("rst_dm_req", 32'(bus.dm_req), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_pm_addr", 32'(bus.pm_addr), 32'd0);
        chk("rst_strobes", 32'({exec_en, load_en, instr_done}), 32'd0);

        // ALU, LD with two wait states, ST zero-wait, then run drops during the next fetch
        push_f(0); push_d(K_EX, 1);
        push_f(1); push_m(10'h155, 1'b0, 3); push_d(K_LD, 5);
        push_f(2); push_m(10'h3FF, 1'b1, 1); push_d(K_ST, 2);
        push_f(3); push_d(K_EX, 1);
        @(negedge clk); #2;
        rst_n = 1'b1;
        run   = 1'b1;
        wait_done(3, 40);
        @(negedge clk); #1;
        run = 1'b0;
        wait_done(4, 20);
        check_idle("stop_fetch", 4);

        // run dropped while the load waits for dm_ready
        push_f(4); push_m(10'h155, 1'b0, 3); push_d(K_LD, 5);
        run = 1'b1;
        wait_dm_req(20);
        run = 1'b0;
        wait_done(5, 20);
        check_idle("stop_mem", 4);

        // NOPs up to 1023, pc wraps to 0
        for (int a = 5; a < 1024; a++) begin
            push_f(a); push_d(K_EX, 1);
        end
        push_f(0); push_d(K_EX, 1);
        run = 1'b1;
        wait_done(1024, 3000);
        @(negedge clk); #1;
        run = 1'b0;
        wait_done(1025, 20);
        check_idle("wrap", 2);
        chk("wrap_err", 32'(err), 32'd0);
        chk("wrap_pc", 32'(bus.pm_addr), 32'd1);

        // LD+ST together: store wins, err sticks; slow program memory
        pm_mem[1] = 16'h7012;
        pm_mem[2] = 16'h0000;
        pm_wait   = 2;
        push_f(1); push_m(10'h012, 1'b1, 1); push_d(K_ST, 2);
        push_f(2); push_d(K_EX, 1);
        run = 1'b1;
        wait_done(1026, 40);
        @(negedge clk); #1;
        run = 1'b0;
        wait_done(1027, 20);
        chk("both_err", 32'(err), 32'd1);
        check_idle("both", 5);
        chk("both_err_sticky", 32'(err), 32'd1);

        // reset while a data transfer is outstanding
        pm_mem[3] = 16'h4155;
        dm_lat[10'h155] = 20;
        pm_wait = 0;
        push_f(3);
        run = 1'b1;
        wait_dm_req(20);
        @(negedge clk); #2;
        chk("pre_rst_dm_req", 32'(bus.dm_req), 32'd1);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        chk("mid_rst_dm_req", 32'(bus.dm_req), 32'd0);
        chk("mid_rst_pc", 32'(bus.pm_addr), 32'd0);
        chk("mid_rst_ir", 32'(ir), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_halted", 32'(halted), 32'd1);
        @(negedge clk); #2;
        rst_n = 1'b1;
        check_idle("post_rst", 3);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
